// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions for the display encoder and reader.
// Segment patterns are active-high with bit6=a ... bit0=g.
package seven_segment_pkg;

    localparam int unsigned SEG_W    = 7;
    localparam int unsigned NIBBLE_W = 4;

    localparam logic [SEG_W-1:0] SEG_0 = 7'h7e;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h6d;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h33;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h5b;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h5f;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h70;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7f;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h7b;

    // Nibble reported for any pattern that is not a decimal digit.
    localparam logic [NIBBLE_W-1:0] SEG_INVALID_NIBBLE = 4'hF;

endpackage

// File: rtl/seven_segment_pattern_decode.sv
// Combinational seven-segment pattern to nibble decoder.
// Ports:
//   i_pattern  - segment pattern, bit6=a ... bit0=g, active-high
//   o_nibble_c - decoded digit value, SEG_INVALID_NIBBLE when not a digit
//   o_err_c    - high when the pattern is not one of the ten digit glyphs
module seven_segment_pattern_decode
    import seven_segment_pkg::*;
(
    input  logic [SEG_W-1:0]    i_pattern,
    output logic [NIBBLE_W-1:0] o_nibble_c,
    output logic                o_err_c
);

    // Digit glyph lookup; everything else (including blank) is an error.
    always_comb begin
        o_nibble_c = SEG_INVALID_NIBBLE;
        o_err_c    = 1'b0;
        case (i_pattern)
            SEG_0:   o_nibble_c = 4'h0;
            SEG_1:   o_nibble_c = 4'h1;
            SEG_2:   o_nibble_c = 4'h2;
            SEG_3:   o_nibble_c = 4'h3;
            SEG_4:   o_nibble_c = 4'h4;
            SEG_5:   o_nibble_c = 4'h5;
            SEG_6:   o_nibble_c = 4'h6;
            SEG_7:   o_nibble_c = 4'h7;
            SEG_8:   o_nibble_c = 4'h8;
            SEG_9:   o_nibble_c = 4'h9;
            default: o_err_c    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_segment_reader.sv
// Seven-segment display bus reader: debounces each multiplexed digit,
// decodes it back to a nibble and assembles complete frames behind a
// single-entry valid/ready output register.
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   io_segIn      - segment pattern, bit6=a ... bit0=g
//   io_digitEn    - one-hot digit strobe, bit i selects slot i
//   io_outReady   - consumer accepts the held frame
//   io_outValid   - a frame is held in the output register
//   io_outDigits  - decoded nibbles, slot i at [4i+3:4i]
//   io_outErr     - per-slot invalid-pattern flags
//   io_overrun    - sticky, a completed frame was dropped
module seven_segment_reader
    import seven_segment_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [6:0]              io_segIn,
    input  logic [NUM_DIGITS-1:0]   io_digitEn,
    input  logic                    io_outReady,
    output logic                    io_outValid,
    output logic [4*NUM_DIGITS-1:0] io_outDigits,
    output logic [NUM_DIGITS-1:0]   io_outErr,
    output logic                    io_overrun
);

    localparam int unsigned IN_W  = SEG_W + NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned DIG_W = NIBBLE_W * NUM_DIGITS;

    logic [IN_W-1:0]       r_prev;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIG_W-1:0]      r_slots;
    logic [NUM_DIGITS-1:0] r_err;
    logic [NUM_DIGITS-1:0] r_seen;
    logic                  r_out_valid;
    logic [DIG_W-1:0]      r_out_digits;
    logic [NUM_DIGITS-1:0] r_out_err;
    logic                  r_overrun;

    logic [IN_W-1:0]       w_in;
    logic                  w_same;
    logic                  w_capture;
    logic                  w_onehot;
    logic                  w_accept;
    logic                  w_frame_done;
    logic                  w_load;
    logic [NUM_DIGITS-1:0] w_seen_next;
    logic [DIG_W-1:0]      w_slots_next;
    logic [NUM_DIGITS-1:0] w_err_next;
    logic [NIBBLE_W-1:0]   w_nibble;
    logic                  w_err;

    seven_segment_pattern_decode u_decode (
        .i_pattern  (io_segIn),
        .o_nibble_c (w_nibble),
        .o_err_c    (w_err)
    );

    assign w_in   = {io_segIn, io_digitEn};
    assign w_same = (w_in == r_prev);

    // Fires once per stable period: the saturated counter never re-enters this value.
    assign w_capture = w_same && (r_cnt == CNT_W'(STABLE_CYCLES - 1));

    assign w_onehot = (io_digitEn != '0) &&
                      ((io_digitEn & (io_digitEn - NUM_DIGITS'(1))) == '0);
    assign w_accept     = w_capture && w_onehot;
    assign w_seen_next  = r_seen | io_digitEn;
    assign w_frame_done = w_accept && (w_seen_next == '1);
    assign w_load       = w_frame_done && (!r_out_valid || io_outReady);

    // Slot contents with the newly captured digit merged in.
    always_comb begin
        w_slots_next = r_slots;
        w_err_next   = r_err;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (io_digitEn[i]) begin
                w_slots_next[NIBBLE_W*i +: NIBBLE_W] = w_nibble;
                w_err_next[i]                        = w_err;
            end
        end
    end

    // Stability tracker.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev <= '0;
            r_cnt  <= '0;
        end else begin
            r_prev <= w_in;
            if (!w_same) begin
                r_cnt <= CNT_W'(1);
            end else if (r_cnt != CNT_W'(STABLE_CYCLES)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Frame assembly; seen clears whether the frame is loaded or dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_slots <= '0;
            r_err   <= '0;
            r_seen  <= '0;
        end else if (w_accept) begin
            r_slots <= w_slots_next;
            r_err   <= w_err_next;
            r_seen  <= w_frame_done ? '0 : w_seen_next;
        end
    end

    // Single-entry output holding register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_digits <= '0;
            r_out_err    <= '0;
            r_overrun    <= 1'b0;
        end else if (w_load) begin
            r_out_valid  <= 1'b1;
            r_out_digits <= w_slots_next;
            r_out_err    <= w_err_next;
        end else begin
            if (w_frame_done) begin
                r_overrun <= 1'b1;
            end
            if (r_out_valid && io_outReady) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign io_outValid  = r_out_valid;
    assign io_outDigits = r_out_digits;
    assign io_outErr    = r_out_err;
    assign io_overrun   = r_overrun;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Self-checking bench for seven_segment_reader (NUM_DIGITS=4, STABLE_CYCLES=3).
module tb_seven_segment_reader;

    localparam int unsigned ND = 4;
    localparam int unsigned SC = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  io_segIn = '0;
    logic [3:0]  io_digitEn = '0;
    logic        io_outReady = 1'b0;
    logic        io_outValid;
    logic [15:0] io_outDigits;
    logic [3:0]  io_outErr;
    logic        io_overrun;

    always #5 clock = ~clock;

    seven_segment_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_segIn     (io_segIn),
        .io_digitEn   (io_digitEn),
        .io_outReady  (io_outReady),
        .io_outValid  (io_outValid),
        .io_outDigits (io_outDigits),
        .io_outErr    (io_outErr),
        .io_overrun   (io_overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int vcount   = 0;
    logic [15:0] cap_digits = '0;
    logic [3:0]  cap_err = '0;

    logic [6:0] seg_tab [10] = '{7'h7e, 7'h30, 7'h6d, 7'h79, 7'h33,
                                 7'h5b, 7'h5f, 7'h70, 7'h7f, 7'h7b};

    // ---------------- reference model ----------------
    logic [10:0] m_last = '0;
    int          m_run = 0;
    logic [3:0]  m_nib [4];
    logic        m_e [4];
    logic [3:0]  m_seen = '0;
    logic        m_valid = 1'b0;
    logic        m_over = 1'b0;
    logic [15:0] m_digits = '0;
    logic [3:0]  m_errv = '0;

    function automatic void decode_ref(input logic [6:0] p, output logic [3:0] n, output logic e);
        n = 4'hF;
        e = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (p == seg_tab[k]) begin
                n = 4'(k);
                e = 1'b0;
            end
        end
    endfunction

    function automatic void model_edge(input logic [6:0] seg, input logic [3:0] en,
                                       input logic rdy, input logic rst);
        logic [10:0] in_v;
        logic        same, was_valid, loaded, e;
        logic [3:0]  n;
        int          idx;
        if (rst) begin
            m_last = '0; m_run = 0; m_seen = '0; m_valid = 1'b0;
            m_over = 1'b0; m_digits = '0; m_errv = '0;
            for (int k = 0; k < 4; k++) begin
                m_nib[k] = '0;
                m_e[k]   = 1'b0;
            end
            return;
        end
        in_v      = {seg, en};
        same      = (in_v == m_last);
        m_run     = same ? m_run + 1 : 1;
        m_last    = in_v;
        was_valid = m_valid;
        loaded    = 1'b0;
        if (same && m_run == int'(SC) && $countones(en) == 1) begin
            idx = 0;
            for (int k = 0; k < 4; k++) if (en[k]) idx = k;
            decode_ref(seg, n, e);
            m_nib[idx]  = n;
            m_e[idx]    = e;
            m_seen[idx] = 1'b1;
            if (m_seen == 4'hF) begin
                m_seen = '0;
                if (!was_valid || rdy) begin
                    for (int k = 0; k < 4; k++) begin
                        m_digits[4*k +: 4] = m_nib[k];
                        m_errv[k]          = m_e[k];
                    end
                    m_valid = 1'b1;
                    loaded  = 1'b1;
                end else begin
                    m_over = 1'b1;
                end
            end
        end
        if (!loaded && was_valid && rdy) m_valid = 1'b0;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic [6:0] seg, input logic [3:0] en, input logic rdy, input logic rst);
        io_segIn    = seg;
        io_digitEn  = en;
        io_outReady = rdy;
        reset       = rst;
        @(posedge clock);
        model_edge(seg, en, rdy, rst);
        #1;
        chk("outValid", 32'(io_outValid), 32'(m_valid));
        chk("outDigits", 32'(io_outDigits), 32'(m_digits));
        chk("outErr", 32'(io_outErr), 32'(m_errv));
        chk("overrun", 32'(io_overrun), 32'(m_over));
        if (io_outValid) begin
            vcount++;
            cap_digits = io_outDigits;
            cap_err    = io_outErr;
        end
    endtask

    task automatic hold(input logic [6:0] seg, input logic [3:0] en, input int n, input logic rdy);
        repeat (n) step(seg, en, rdy, 1'b0);
    endtask

    task automatic frame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                         input logic [6:0] s0, input logic rdy);
        hold(s3, 4'b1000, 4, rdy);
        hold(s2, 4'b0100, 4, rdy);
        hold(s1, 4'b0010, 4, rdy);
        hold(s0, 4'b0001, 4, rdy);
    endtask

    typedef struct {
        logic [6:0] seg;
        logic [3:0] nib;
        logic       err;
    } dec_vec_t;

    initial begin
        dec_vec_t vecs [15];
        int base;

        vecs = '{'{7'h7e, 4'h0, 1'b0}, '{7'h30, 4'h1, 1'b0}, '{7'h6d, 4'h2, 1'b0},
                 '{7'h79, 4'h3, 1'b0}, '{7'h33, 4'h4, 1'b0}, '{7'h5b, 4'h5, 1'b0},
                 '{7'h5f, 4'h6, 1'b0}, '{7'h70, 4'h7, 1'b0}, '{7'h7f, 4'h8, 1'b0},
                 '{7'h7b, 4'h9, 1'b0}, '{7'h00, 4'hF, 1'b1}, '{7'h01, 4'hF, 1'b1},
                 '{7'h7d, 4'hF, 1'b1}, '{7'h3f, 4'hF, 1'b1}, '{7'h06, 4'hF, 1'b1}};

        // Reset state
        step(7'h00, 4'b0000, 1'b0, 1'b1);
        step(7'h00, 4'b0000, 1'b0, 1'b1);
        chk("rst_valid", 32'(io_outValid), 32'd0);
        chk("rst_digits", 32'(io_outDigits), 32'd0);
        chk("rst_err", 32'(io_outErr), 32'd0);
        chk("rst_overrun", 32'(io_overrun), 32'd0);

        // 1. Basic frame
        base = vcount;
        frame(7'h30, 7'h6d, 7'h79, 7'h33, 1'b1);
        chk("t1_pulses", 32'(vcount - base), 32'd1);
        chk("t1_digits", 32'(cap_digits), 32'h1234);
        chk("t1_err", 32'(cap_err), 32'h0);
        chk("t1_overrun", 32'(io_overrun), 32'd0);

        // Decode table, one pattern per frame in slot 0
        for (int v = 0; v < 15; v++) begin
            base = vcount;
            frame(7'h30, 7'h30, 7'h30, vecs[v].seg, 1'b1);
            chk("dec_pulse", 32'(vcount - base), 32'd1);
            chk("dec_digits", 32'(cap_digits), 32'({12'h111, vecs[v].nib}));
            chk("dec_err", 32'(cap_err), 32'({3'b000, vecs[v].err}));
        end

        // 2. Glitch then long hold
        base = vcount;
        hold(7'h7e, 4'b0001, 2, 1'b1);
        hold(7'h00, 4'b0000, 3, 1'b1);
        hold(7'h5b, 4'b1000, 4, 1'b1);
        hold(7'h5f, 4'b0100, 4, 1'b1);
        hold(7'h70, 4'b0010, 4, 1'b1);
        chk("t2_no_frame", 32'(vcount - base), 32'd0);
        hold(7'h7e, 4'b0001, 20, 1'b1);
        chk("t2_one_frame", 32'(vcount - base), 32'd1);
        chk("t2_digits", 32'(cap_digits), 32'h5670);

        // 3. Invalid pattern in slot 1
        base = vcount;
        frame(7'h7b, 7'h7f, 7'h00, 7'h30, 1'b1);
        chk("t3_pulse", 32'(vcount - base), 32'd1);
        chk("t3_digits", 32'(cap_digits), 32'h98F1);
        chk("t3_err", 32'(cap_err), 32'b0010);

        // 4. Backpressure: second frame dropped
        frame(7'h30, 7'h6d, 7'h79, 7'h33, 1'b0);
        frame(7'h5b, 7'h5f, 7'h70, 7'h7f, 1'b0);
        chk("t4_valid_held", 32'(io_outValid), 32'd1);
        chk("t4_digits_held", 32'(io_outDigits), 32'h1234);
        chk("t4_overrun", 32'(io_overrun), 32'd1);
        step(7'h00, 4'b0000, 1'b1, 1'b0);
        chk("t4_xfer_valid", 32'(io_outValid), 32'd0);
        chk("t4_xfer_digits", 32'(io_outDigits), 32'h1234);
        // Frame completes on the same edge as a transfer
        frame(7'h7b, 7'h7f, 7'h70, 7'h5f, 1'b0);
        chk("t4_c_digits", 32'(io_outDigits), 32'h9876);
        hold(7'h7e, 4'b1000, 4, 1'b0);
        hold(7'h30, 4'b0100, 4, 1'b0);
        hold(7'h79, 4'b0010, 4, 1'b0);
        hold(7'h5b, 4'b0001, 2, 1'b0);
        chk("t4_pre_valid", 32'(io_outValid), 32'd1);
        step(7'h5b, 4'b0001, 1'b1, 1'b0);
        chk("t4_same_valid", 32'(io_outValid), 32'd1);
        chk("t4_same_digits", 32'(io_outDigits), 32'h0135);
        step(7'h5b, 4'b0001, 1'b1, 1'b0);
        chk("t4_final_valid", 32'(io_outValid), 32'd0);

        // 5. Multi-hot and zero enables ignored
        base = vcount;
        hold(7'h30, 4'b0011, 10, 1'b1);
        hold(7'h30, 4'b0000, 10, 1'b1);
        hold(7'h6d, 4'b1000, 4, 1'b1);
        hold(7'h79, 4'b0100, 4, 1'b1);
        hold(7'h33, 4'b0010, 4, 1'b1);
        chk("t5_no_frame", 32'(vcount - base), 32'd0);
        hold(7'h5b, 4'b0001, 4, 1'b1);
        chk("t5_one_frame", 32'(vcount - base), 32'd1);
        chk("t5_digits", 32'(cap_digits), 32'h2345);

        // 6. Reset mid-frame
        hold(7'h30, 4'b1000, 4, 1'b1);
        hold(7'h6d, 4'b0100, 4, 1'b1);
        step(7'h00, 4'b0000, 1'b1, 1'b1);
        chk("t6_valid", 32'(io_outValid), 32'd0);
        chk("t6_digits", 32'(io_outDigits), 32'd0);
        chk("t6_err", 32'(io_outErr), 32'd0);
        chk("t6_overrun", 32'(io_overrun), 32'd0);
        base = vcount;
        hold(7'h79, 4'b0010, 4, 1'b1);
        hold(7'h33, 4'b0001, 4, 1'b1);
        chk("t6_no_frame", 32'(vcount - base), 32'd0);
        hold(7'h30, 4'b1000, 4, 1'b1);
        hold(7'h6d, 4'b0100, 4, 1'b1);
        chk("t6_frame", 32'(vcount - base), 32'd1);
        chk("t6_frame_digits", 32'(cap_digits), 32'h1234);

        // Randomized traffic against the model
        for (int it = 0; it < 300; it++) begin
            logic [6:0] s;
            logic [3:0] e;
            int h;
            s = ($urandom_range(0, 4) == 0) ? 7'($urandom) : seg_tab[$urandom_range(0, 9)];
            e = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            h = $urandom_range(1, 6);
            for (int k = 0; k < h; k++) begin
                step(s, e, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
